// File: rtl/seg7_bus_arbiter.sv
// seg7_bus_arbiter
//   Shares the single address/data/WE port of the 7-segment display peripheral between
//   N_REQ requesters. Each request is granted round-robin, its payload is latched and driven
//   toward the peripheral for HOLD_CYC cycles, a one-cycle ack goes back to the requester,
//   and GAP_CYC idle cycles follow before the next arbitration.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   req_i          per-requester request, held until ack
//   req_we_i       per-requester write enable (0 = read access, periph_we_o stays low)
//   req_addr_i     packed addresses, requester i at [i*AW +: AW]
//   req_data_i     packed write data, requester i at [i*DW +: DW]
//   ack_o          one-cycle completion pulse to the granted requester
//   busy_o         high whenever the arbiter is not idle
//   grant_id_o     index of the current/last granted requester
//   periph_addr_o  address to the peripheral
//   periph_data_o  write data to the peripheral
//   periph_we_o    write enable to the peripheral
module seg7_bus_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned GAP_CYC  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    req_we_i,
  input  logic [N_REQ*AW-1:0] req_addr_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic                busy_o,
  output logic [2:0]          grant_id_o,
  output logic [AW-1:0]       periph_addr_o,
  output logic [DW-1:0]       periph_data_o,
  output logic                periph_we_o
);

  // The phase counter counts down from (cycles - 1) to 0 in DRIVE and GAP.
  localparam int unsigned MaxCyc = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [2:0]      LastReq  = 3'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StAck, StGap} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 we_q, we_d;

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ... modulo N_REQ.
  int unsigned pick_idx;
  logic        pick_vld;

  always_comb begin
    int unsigned idx;
    pick_idx = 0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!pick_vld && req_i[idx]) begin
        pick_idx = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    ack_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StDrive;
          cnt_d   = HoldLoad;
          grant_d = 3'(pick_idx);
          addr_d  = req_addr_i[pick_idx*AW +: AW];
          data_d  = req_data_i[pick_idx*DW +: DW];
          we_d    = req_we_i[pick_idx];
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StAck;
          we_d    = 1'b0;
          ack_d   = N_REQ'(1) << grant_q;
          // Rotate so the requester just served has the lowest priority next time.
          ptr_d   = (grant_q == LastReq) ? 3'd0 : grant_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        if (GAP_CYC > 0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign ack_o         = ack_q;
  assign busy_o        = busy_q;
  assign grant_id_o    = grant_q;
  assign periph_addr_o = addr_q;
  assign periph_data_o = data_q;
  assign periph_we_o   = we_q;

endmodule
